// File: rtl/multiplicador_seq_if.sv
// Operand/result bundle for the sequential multiplier: the requester drives
// start and operands, the multiplier returns busy, done and the product.
interface multiplicador_seq_if #(
    parameter int WIDTH = 8
) ();
    logic                 start;
    logic                 sgn;
    logic [WIDTH-1:0]     b_in;
    logic [WIDTH-1:0]     q_in;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   p_out;

    modport master (
        output start, sgn, b_in, q_in,
        input  busy, done, p_out
    );

    modport slave (
        input  start, sgn, b_in, q_in,
        output busy, done, p_out
    );
endinterface

// File: rtl/multiplicador_seq.sv
// Shift-and-add multiplier, one iteration per clock, unsigned or two's-complement
// signed; the signed mode subtracts the multiplicand on the final (sign) bit.
module multiplicador_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    multiplicador_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;

    logic [WIDTH:0]       a_reg;
    logic [WIDTH:0]       b_ext;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       a_next;
    logic [WIDTH-1:0]     q_reg;
    logic [WIDTH-1:0]     q_next;
    logic [WIDTH-1:0]     b_reg;
    logic [CW-1:0]        cnt;
    logic                 sgn_reg;
    logic                 accept;
    logic                 last_iter;
    logic                 shift_in;
    logic [2*WIDTH-1:0]   p_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Start is only honoured in IDLE, so requests while busy fall through silently.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                bus.busy = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.busy   = 1'b1;
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The guard bit of A holds the carry (unsigned) or the true sign (signed),
    // so the add never overflows and the shift can feed it back into A.
    always_comb begin
        last_iter = (cnt == '0);
        b_ext     = sgn_reg ? {b_reg[WIDTH-1], b_reg} : {1'b0, b_reg};
        sum       = a_reg;
        if (q_reg[0]) begin
            if (sgn_reg && last_iter) begin
                sum = a_reg - b_ext;
            end else begin
                sum = a_reg + b_ext;
            end
        end
        shift_in = sgn_reg ? sum[WIDTH] : 1'b0;
        a_next   = {shift_in, sum[WIDTH:1]};
        q_next   = {sum[0], q_reg[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg   <= '0;
            q_reg   <= '0;
            b_reg   <= '0;
            cnt     <= '0;
            sgn_reg <= 1'b0;
            p_reg   <= '0;
        end else begin
            if (accept) begin
                a_reg   <= '0;
                q_reg   <= bus.q_in;
                b_reg   <= bus.b_in;
                sgn_reg <= bus.sgn;
                cnt     <= CW'(WIDTH - 1);
            end else if (state == CALC) begin
                a_reg <= a_next;
                q_reg <= q_next;
                cnt   <= cnt - 1'b1;
                if (last_iter) begin
                    p_reg <= {a_next[WIDTH-1:0], q_next};
                end
            end
        end
    end

    assign bus.p_out = p_reg;

endmodule

// File: tb/tb_multiplicador_seq.sv
// Self-checking bench: directed and exhaustive runs on a 4-bit multiplier,
// back-to-back random streams on 8- and 16-bit multipliers.
module tb_multiplicador_seq;
    logic clk;
    logic rst;
    int   assert_count;
    int   fail_count;

    multiplicador_seq_if #(.WIDTH(4))  bus4 ();
    multiplicador_seq_if #(.WIDTH(8))  bus8 ();
    multiplicador_seq_if #(.WIDTH(16)) bus16 ();

    multiplicador_seq #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));
    multiplicador_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
    multiplicador_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Exact product from plain integer arithmetic, truncated to 2*w bits.
    function automatic logic [63:0] ref_product(input int w, input bit s, input logic [63:0] b,
                                                input logic [63:0] q);
        longint bv;
        longint qv;
        longint p;
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        bv = longint'(b & mask);
        qv = longint'(q & mask);
        if (s && b[w-1]) bv = bv - (longint'(1) << w);
        if (s && q[w-1]) qv = qv - (longint'(1) << w);
        p = bv * qv;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // One 4-bit operation from an idle negedge; ends at a negedge with the DUT idle.
    task automatic apply_stimulus(input string tag, input bit s, input logic [3:0] b,
                                  input logic [3:0] q, input logic [7:0] exp);
        logic [7:0] prev;
        logic [7:0] p_done;
        int         lat;
        int         busy_cyc;
        bit         held;
        prev = bus4.p_out;
        bus4.start = 1'b1;
        bus4.sgn   = s;
        bus4.b_in  = b;
        bus4.q_in  = q;
        @(negedge clk);
        bus4.start = 1'b0;
        bus4.sgn   = 1'($urandom);
        bus4.b_in  = 4'($urandom);
        bus4.q_in  = 4'($urandom);
        lat      = -1;
        busy_cyc = 0;
        held     = 1'b1;
        p_done   = '0;
        for (int n = 0; n <= 20 && lat < 0; n++) begin
            if (n > 0) @(negedge clk);
            if (bus4.busy) busy_cyc++;
            if (bus4.done) begin
                lat    = n;
                p_done = bus4.p_out;
            end else if (bus4.p_out !== prev) begin
                held = 1'b0;
            end
        end
        check_output($sformatf("%s latency", tag), 64'(lat), 64'd4);
        check_output($sformatf("%s product", tag), 64'(p_done), 64'(exp));
        check_output($sformatf("%s p_out held", tag), 64'(held), 64'd1);
        check_output($sformatf("%s busy cycles", tag), 64'(busy_cyc), 64'd5);
        @(negedge clk);
        check_output($sformatf("%s idle after done", tag), {62'd0, bus4.busy, bus4.done}, 64'd0);
    endtask

    function automatic logic get_busy(input int w);
        return (w == 8) ? bus8.busy : bus16.busy;
    endfunction

    function automatic logic get_done(input int w);
        return (w == 8) ? bus8.done : bus16.done;
    endfunction

    function automatic logic [63:0] get_p(input int w);
        return (w == 8) ? 64'(bus8.p_out) : 64'(bus16.p_out);
    endfunction

    task automatic drive_ops(input int w, input bit st, input bit s, input logic [63:0] b,
                             input logic [63:0] q);
        if (w == 8) begin
            bus8.start = st;
            bus8.sgn   = s;
            bus8.b_in  = b[7:0];
            bus8.q_in  = q[7:0];
        end else begin
            bus16.start = st;
            bus16.sgn   = s;
            bus16.b_in  = b[15:0];
            bus16.q_in  = q[15:0];
        end
    endtask

    function automatic logic [63:0] rand_operand(input int w);
        logic [63:0] v;
        v = {32'($urandom), 32'($urandom)} & ((64'd1 << w) - 64'd1);
        if ($urandom_range(0, 7) == 0) v = 64'd1 << (w - 1);
        return v;
    endfunction

    // Start held high: an operation is accepted on each IDLE edge, so dones
    // recur every WIDTH iterations plus the DONE and IDLE cycles.
    task automatic run_stream(input int w, input int n_ops);
        bit          pend_s[$];
        logic [63:0] pend_b[$];
        logic [63:0] pend_q[$];
        bit          cur_s;
        logic [63:0] cur_b;
        logic [63:0] cur_q;
        bit          prev_busy;
        int          last_done;
        int          dones;
        int          cyc;
        int          budget;
        cur_s = 1'($urandom);
        cur_b = rand_operand(w);
        cur_q = rand_operand(w);
        drive_ops(w, 1'b1, cur_s, cur_b, cur_q);
        prev_busy = 1'b0;
        last_done = -1;
        dones     = 0;
        cyc       = 0;
        budget    = n_ops * (w + 2) + 50;
        while (cyc < budget && dones < n_ops) begin
            @(negedge clk);
            cyc++;
            if (get_done(w)) begin
                if (pend_s.size() == 0) begin
                    check_output($sformatf("w%0d unexpected done", w), 64'd1, 64'd0);
                end else begin
                    check_output($sformatf("w%0d op%0d product", w, dones), get_p(w),
                                 ref_product(w, pend_s[0], pend_b[0], pend_q[0]));
                    void'(pend_s.pop_front());
                    void'(pend_b.pop_front());
                    void'(pend_q.pop_front());
                end
                if (last_done >= 0)
                    check_output($sformatf("w%0d op%0d done spacing", w, dones),
                                 64'(cyc - last_done), 64'(w + 2));
                last_done = cyc;
                dones++;
            end
            if (get_busy(w) && !prev_busy) begin
                pend_s.push_back(cur_s);
                pend_b.push_back(cur_b);
                pend_q.push_back(cur_q);
                cur_s = 1'($urandom);
                cur_b = rand_operand(w);
                cur_q = rand_operand(w);
                drive_ops(w, 1'b1, cur_s, cur_b, cur_q);
            end
            prev_busy = get_busy(w);
        end
        if (dones < n_ops)
            check_output($sformatf("w%0d stream timeout", w), 64'(dones), 64'(n_ops));
        drive_ops(w, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (w + 3) @(negedge clk);
    endtask

    initial begin
        int  n_done;
        bit  spurious;
        logic [7:0] p_seen;
        assert_count = 0;
        fail_count   = 0;
        rst = 1'b1;
        bus4.start = 1'b0; bus4.sgn = 1'b0; bus4.b_in = '0; bus4.q_in = '0;
        drive_ops(8, 1'b0, 1'b0, 64'd0, 64'd0);
        drive_ops(16, 1'b0, 1'b0, 64'd0, 64'd0);
        #1 rst = 1'b0;
        #1;
        check_output("reset busy", 64'(bus4.busy), 64'd0);
        check_output("reset done", 64'(bus4.done), 64'd0);
        check_output("reset p_out", 64'(bus4.p_out), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        apply_stimulus("unsigned F*F", 1'b0, 4'b1111, 4'b1111, 8'hE1);
        apply_stimulus("signed 8*8", 1'b1, 4'b1000, 4'b1000, 8'h40);
        apply_stimulus("signed 8*7", 1'b1, 4'b1000, 4'b0111, 8'hC8);
        apply_stimulus("signed 7*F", 1'b1, 4'b0111, 4'b1111, 8'hF9);
        apply_stimulus("unsigned F*2", 1'b0, 4'b1111, 4'b0010, 8'h1E);
        apply_stimulus("signed F*2", 1'b1, 4'b1111, 4'b0010, 8'hFE);

        bus4.start = 1'b1; bus4.sgn = 1'b0; bus4.b_in = 4'b0011; bus4.q_in = 4'b0101;
        @(negedge clk);
        bus4.start = 1'b0;
        @(negedge clk);
        bus4.start = 1'b1; bus4.b_in = 4'b1111; bus4.q_in = 4'b1111;
        @(negedge clk);
        bus4.start = 1'b0;
        n_done = 0;
        p_seen = '0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (bus4.done) begin
                n_done++;
                p_seen = bus4.p_out;
            end
        end
        check_output("busy protect done count", 64'(n_done), 64'd1);
        check_output("busy protect product", 64'(p_seen), 64'h0F);

        bus4.start = 1'b1; bus4.sgn = 1'b0; bus4.b_in = 4'b1111; bus4.q_in = 4'b1111;
        @(negedge clk);
        bus4.start = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check_output("mid-op reset busy", 64'(bus4.busy), 64'd0);
        check_output("mid-op reset done", 64'(bus4.done), 64'd0);
        check_output("mid-op reset p_out", 64'(bus4.p_out), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        spurious = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (bus4.done || bus4.busy) spurious = 1'b1;
        end
        check_output("no activity after abort", 64'(spurious), 64'd0);
        apply_stimulus("after reset 2*3", 1'b0, 4'b0010, 4'b0011, 8'h06);

        for (int s = 0; s < 2; s++)
            for (int b = 0; b < 16; b++)
                for (int q = 0; q < 16; q++)
                    apply_stimulus($sformatf("exh s%0d %0h*%0h", s, b, q), 1'(s), 4'(b), 4'(q),
                                   8'(ref_product(4, 1'(s), 64'(b), 64'(q))));

        run_stream(8, 60);
        run_stream(16, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global timeout: observed running expected finished");
        $fatal(1, "[TB] global timeout");
    end
endmodule
